writeback_cycle: RTL and testbench

//  Final pipeline stage of the 16-bit processor; the write side of the register file read by decode_cycle.
//  - Accepts retiring instructions from the execute/memory stage over a valid/ready handshake.
//  - Selects the result source, waits for load data where needed, then drives writedata/writereg/regwrite into the register file.
//  - Exposes a forwarding copy and a retired-instruction counter.

---
 rtl/writeback_cycle_if.sv | 35 +++
 rtl/writeback_cycle.sv | 120 ++++++++++++
 tb/tb_writeback_cycle.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/writeback_cycle_if.sv
// Writeback stage bus: retiring-instruction handshake, load return path and register-file write side.
interface writeback_cycle_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_rd;
  logic             in_regwrite;
  logic [1:0]       in_wbsel;
  logic [WIDTH-1:0] in_aluout;
  logic [WIDTH-1:0] in_pc;
  logic [WIDTH-1:0] in_imm;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] writedata;
  logic [3:0]       writereg;
  logic             regwrite;
  logic             fwd_valid;
  logic             mem_err;
  logic [15:0]      retired_count;

  // Upstream/environment side: drives instructions and load data, observes the write port.
  modport master (
    output in_valid, in_rd, in_regwrite, in_wbsel, in_aluout, in_pc, in_imm,
    output mem_rvalid, mem_rdata,
    input  in_ready, writedata, writereg, regwrite, fwd_valid, mem_err, retired_count
  );

  // Writeback stage side.
  modport slave (
    input  in_valid, in_rd, in_regwrite, in_wbsel, in_aluout, in_pc, in_imm,
    input  mem_rvalid, mem_rdata,
    output in_ready, writedata, writereg, regwrite, fwd_valid, mem_err, retired_count
  );
endinterface

// File: rtl/writeback_cycle.sv
// Final pipeline stage: picks the result source, waits for load data, writes the register file.
module writeback_cycle #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  writeback_cycle_if.slave  bus
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC2 = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  state_t           state;
  logic [CW-1:0]    tcnt;
  logic [3:0]       pend_rd;
  logic             pend_we;
  logic             in_ready;
  logic [WIDTH-1:0] writedata;
  logic [3:0]       writereg;
  logic             regwrite;
  logic             fwd_valid;
  logic             mem_err;
  logic [15:0]      retired_count;
  logic [WIDTH-1:0] nonload_data_c;
  logic             we_c;

  // Result mux for non-load instructions and effective write enable (r0 never written).
  always_comb begin
    nonload_data_c = bus.in_imm;
    if (bus.in_wbsel == WB_ALU)      nonload_data_c = bus.in_aluout;
    else if (bus.in_wbsel == WB_PC2) nonload_data_c = bus.in_pc + WIDTH'(2);
    we_c = bus.in_regwrite && (bus.in_rd != 4'd0);
  end

  // Stage FSM with registered register-file and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tcnt          <= '0;
      pend_rd       <= 4'd0;
      pend_we       <= 1'b0;
      in_ready      <= 1'b1;
      writedata     <= '0;
      writereg      <= 4'd0;
      regwrite      <= 1'b0;
      fwd_valid     <= 1'b0;
      mem_err       <= 1'b0;
      retired_count <= 16'd0;
    end else begin
      regwrite  <= 1'b0;
      fwd_valid <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        IDLE, WRITE: begin
          if (state == WRITE) retired_count <= retired_count + 16'd1;
          // in_ready is high in both states, so in_valid alone means accept.
          if (bus.in_valid) begin
            if (bus.in_wbsel == WB_MEM) begin
              state    <= WAIT_MEM;
              in_ready <= 1'b0;
              tcnt     <= '0;
              pend_rd  <= bus.in_rd;
              pend_we  <= we_c;
            end else begin
              state    <= WRITE;
              in_ready <= 1'b1;
              if (we_c) begin
                writedata <= nonload_data_c;
                writereg  <= bus.in_rd;
                regwrite  <= 1'b1;
                fwd_valid <= 1'b1;
              end
            end
          end else begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        end
        WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            state    <= WRITE;
            in_ready <= 1'b1;
            if (pend_we) begin
              writedata <= bus.mem_rdata;
              writereg  <= pend_rd;
              regwrite  <= 1'b1;
              fwd_valid <= 1'b1;
            end
          end else if (tcnt == CW'(MEM_TIMEOUT - 1)) begin
            // Load abandoned: flag it, nothing written, nothing retired.
            state    <= IDLE;
            in_ready <= 1'b1;
            mem_err  <= 1'b1;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.writedata     = writedata;
  assign bus.writereg      = writereg;
  assign bus.regwrite      = regwrite;
  assign bus.fwd_valid     = fwd_valid;
  assign bus.mem_err       = mem_err;
  assign bus.retired_count = retired_count;

endmodule

// File: tb/tb_writeback_cycle.sv
// Directed bench for writeback_cycle with hand-computed expectations.
module tb_writeback_cycle;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  writeback_cycle_if #(.WIDTH(16)) bus ();

  writeback_cycle #(.WIDTH(16), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [15:0] alu, input logic [15:0] pc, input logic [15:0] imm);
    bus.in_valid    = v;
    bus.in_rd       = rd;
    bus.in_regwrite = rw;
    bus.in_wbsel    = sel;
    bus.in_aluout   = alu;
    bus.in_pc       = pc;
    bus.in_imm      = imm;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0;

    // 1: reset
    step();
    step();
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_regwrite", 32'(bus.regwrite), 32'd0);
    chk("rst_writedata", 32'(bus.writedata), 32'd0);
    chk("rst_retired", 32'(bus.retired_count), 32'd0);
    chk("rst_memerr", 32'(bus.mem_err), 32'd0);
    rst = 1'b0;
    step();

    // 2: ALU write to r6
    drive(1'b1, 4'd6, 1'b1, 2'b00, 16'h1234, 16'h0100, 16'h0);
    step();
    drive(1'b0, 4'd0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0);
    chk("alu_regwrite", 32'(bus.regwrite), 32'd1);
    chk("alu_fwd", 32'(bus.fwd_valid), 32'd1);
    chk("alu_writereg", 32'(bus.writereg), 32'd6);
    chk("alu_writedata", 32'(bus.writedata), 32'h1234);
    step();
    chk("alu_pulse_end", 32'(bus.regwrite), 32'd0);
    chk("alu_retired", 32'(bus.retired_count), 32'd1);
    chk("alu_hold", 32'(bus.writedata), 32'h1234);

    // 3: load to r3, rvalid on the accept edge must be ignored, real data after 4 cycles
    drive(1'b1, 4'd3, 1'b1, 2'b01, 16'h5555, 16'h0, 16'h0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'hDEAD;
    step();
    drive(1'b0, 4'd0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0);
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ld_ready_low", 32'(bus.in_ready), 32'd0);
      chk("ld_no_write", 32'(bus.regwrite), 32'd0);
      step();
    end
    chk("ld_ready_low4", 32'(bus.in_ready), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'hBEEF;
    step();
    bus.mem_rvalid = 1'b0;
    chk("ld_regwrite", 32'(bus.regwrite), 32'd1);
    chk("ld_writedata", 32'(bus.writedata), 32'hBEEF);
    chk("ld_writereg", 32'(bus.writereg), 32'd3);
    chk("ld_ready_back", 32'(bus.in_ready), 32'd1);
    step();
    chk("ld_retired", 32'(bus.retired_count), 32'd2);

    // 4: link with PC wrap, then back-to-back IMM
    drive(1'b1, 4'd15, 1'b1, 2'b10, 16'h7777, 16'hFFFE, 16'h0);
    step();
    drive(1'b1, 4'd2, 1'b1, 2'b11, 16'h7777, 16'h0, 16'h00C2);
    chk("link_regwrite", 32'(bus.regwrite), 32'd1);
    chk("link_writedata", 32'(bus.writedata), 32'h0000);
    chk("link_writereg", 32'(bus.writereg), 32'd15);
    step();
    drive(1'b0, 4'd0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0);
    chk("imm_regwrite", 32'(bus.regwrite), 32'd1);
    chk("imm_writedata", 32'(bus.writedata), 32'h00C2);
    chk("imm_writereg", 32'(bus.writereg), 32'd2);
    chk("b2b_retired", 32'(bus.retired_count), 32'd3);
    step();
    chk("imm_pulse_end", 32'(bus.regwrite), 32'd0);
    chk("imm_retired", 32'(bus.retired_count), 32'd4);

    // 5: write to r0 is suppressed but still retires
    drive(1'b1, 4'd0, 1'b1, 2'b00, 16'hFFFF, 16'h0, 16'h0);
    step();
    drive(1'b0, 4'd0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0);
    chk("r0_regwrite", 32'(bus.regwrite), 32'd0);
    chk("r0_fwd", 32'(bus.fwd_valid), 32'd0);
    chk("r0_hold_data", 32'(bus.writedata), 32'h00C2);
    chk("r0_hold_reg", 32'(bus.writereg), 32'd2);
    step();
    chk("r0_retired", 32'(bus.retired_count), 32'd5);

    // 6: load timeout after 15 cycles, late rvalid dropped
    drive(1'b1, 4'd5, 1'b1, 2'b01, 16'h0, 16'h0, 16'h0);
    step();
    drive(1'b0, 4'd0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 14; i++) begin
      chk("to_wait_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    chk("to_no_err_early", 32'(bus.mem_err), 32'd0);
    step();
    chk("to_mem_err", 32'(bus.mem_err), 32'd1);
    chk("to_no_write", 32'(bus.regwrite), 32'd0);
    chk("to_ready", 32'(bus.in_ready), 32'd1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'h1111;
    step();
    bus.mem_rvalid = 1'b0;
    chk("to_err_pulse", 32'(bus.mem_err), 32'd0);
    chk("late_rvalid_write", 32'(bus.regwrite), 32'd0);
    chk("late_rvalid_data", 32'(bus.writedata), 32'h00C2);
    chk("to_retired", 32'(bus.retired_count), 32'd5);

    // 6b: reset during a second wait abandons the load
    drive(1'b1, 4'd7, 1'b1, 2'b01, 16'h0, 16'h0, 16'h0);
    step();
    drive(1'b0, 4'd0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0);
    step();
    chk("rst2_waiting", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_ready", 32'(bus.in_ready), 32'd1);
    chk("rst2_regwrite", 32'(bus.regwrite), 32'd0);
    chk("rst2_memerr", 32'(bus.mem_err), 32'd0);
    chk("rst2_retired", 32'(bus.retired_count), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'h2222;
    step();
    bus.mem_rvalid = 1'b0;
    chk("rst2_no_write", 32'(bus.regwrite), 32'd0);
    chk("rst2_data", 32'(bus.writedata), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
